// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding and default constants for the WS2812 chain sequencer
package ws2812_pkg;
    localparam int WS2812_COLOUR_W = 8;
    localparam int WS2812_LATCH_CYCLES = 6650;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_LATCH
    } state_t;
endpackage

// File: rtl/ws2812_colour_ram.sv
// ws2812_colour_ram: per-LED colour table, async-low clear, combinational read; out-of-range writes dropped
import ws2812_pkg::*;
module ws2812_colour_ram #(
    parameter int NUM_LEDS = 8,
    parameter int COLOUR_W = WS2812_COLOUR_W,
    parameter int ADDR_W = 3
) (
    input  logic                i_Clock,
    input  logic                i_Rstn,
    input  logic                i_WrEn,
    input  logic [ADDR_W-1:0]   i_WrAddr,
    input  logic [COLOUR_W-1:0] i_WrData,
    input  logic [ADDR_W-1:0]   i_RdAddr,
    output logic [COLOUR_W-1:0] o_RdData
);
    logic [COLOUR_W-1:0] mem [NUM_LEDS];
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_entry
        always_ff @(posedge i_Clock or negedge i_Rstn)
            if (!i_Rstn) mem[i] <= '0;
            else if (i_WrEn && i_WrAddr == ADDR_W'(i)) mem[i] <= i_WrData;
    end
    assign o_RdData = mem[i_RdAddr];
endmodule

// File: rtl/ws2812_chain_sequencer.sv
// ws2812_chain_sequencer: streams the colour table through a WS2812 driver; WS2812_AUTO_REFRESH_EN makes frames free-running
import ws2812_pkg::*;
module ws2812_chain_sequencer #(
    parameter int NUM_LEDS = 8,
    parameter int COLOUR_W = WS2812_COLOUR_W,
    parameter int LATCH_CYCLES = WS2812_LATCH_CYCLES,
    parameter int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                i_Clock,
    input  logic                i_Rstn,
    input  logic                i_WrEn,
    input  logic [ADDR_W-1:0]   i_WrAddr,
    input  logic [COLOUR_W-1:0] i_WrData,
    input  logic                i_Refresh,
    output logic                o_Busy,
    output logic                o_FrameDone,
    output logic                o_Start,
    output logic [COLOUR_W-1:0] o_Colour,
    input  logic                i_Ready
);
`ifdef WS2812_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int CNT_W = $clog2(LATCH_CYCLES) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);
    state_t state;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0] cnt;
    logic pending;
    logic req;
    logic [COLOUR_W-1:0] rd_data;
    ws2812_colour_ram #(.NUM_LEDS(NUM_LEDS), .COLOUR_W(COLOUR_W), .ADDR_W(ADDR_W)) u_ram (
        .i_Clock (i_Clock),
        .i_Rstn  (i_Rstn),
        .i_WrEn  (i_WrEn),
        .i_WrAddr(i_WrAddr),
        .i_WrData(i_WrData),
        .i_RdAddr(index),
        .o_RdData(rd_data)
    );
    assign req = AUTO || i_Refresh || pending;
    always_ff @(posedge i_Clock or negedge i_Rstn)
        if (!i_Rstn) begin
            state       <= S_IDLE;
            index       <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            o_Busy      <= 1'b0;
            o_FrameDone <= 1'b0;
            o_Start     <= 1'b0;
            o_Colour    <= '0;
        end else begin
            o_Start     <= 1'b0;
            o_FrameDone <= 1'b0;
            if (i_Refresh && state != S_IDLE) pending <= 1'b1;
            case (state)
                S_IDLE: if (req) begin
                    state   <= S_LOAD;
                    index   <= '0;
                    pending <= 1'b0;
                    o_Busy  <= 1'b1;
                end
                // colour is only latched when the driver is ready, so it never moves under a busy driver
                S_LOAD: if (i_Ready) begin
                    o_Colour <= rd_data;
                    o_Start  <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: state <= S_WAIT_ACK;
                S_WAIT_ACK: if (!i_Ready) state <= S_WAIT_DONE;
                S_WAIT_DONE: if (i_Ready) begin
                    if (index == LAST) begin
                        state <= S_LATCH;
                        cnt   <= CNT_W'(LATCH_CYCLES - 1);
                    end else begin
                        index <= index + ADDR_W'(1);
                        state <= S_LOAD;
                    end
                end
                S_LATCH: if (cnt == '0) begin
                    state       <= S_IDLE;
                    o_Busy      <= 1'b0;
                    o_FrameDone <= 1'b1;
                end else cnt <= cnt - CNT_W'(1);
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_ws2812_chain_sequencer.sv
// tb_ws2812_chain_sequencer: directed vectors and corner sequences against a 10-cycle-busy driver model
module tb_ws2812_chain_sequencer;
    localparam int N = 5;
    localparam int L = 20;
    localparam int AW = 3;
    localparam int FRAME_CYC = N * 12 + L + 1;
    typedef struct packed {
        logic [4:0]  mask;
        logic [39:0] wr;
        logic [7:0]  junk;
        logic [39:0] exp;
    } vec_t;
    logic i_Clock = 0, i_Rstn = 0, i_WrEn = 0, i_Refresh = 0, i_Ready = 1;
    logic [AW-1:0] i_WrAddr = '0;
    logic [7:0] i_WrData = '0;
    logic o_Busy, o_FrameDone, o_Start;
    logic [7:0] o_Colour;
    int total = 0, bad = 0, cyc = 0, drv_cnt = 0, fd_cnt = 0, t_fd = 0, t_rdy = 0, t_load = 0;
    bit force_low = 0, prev_busy = 0, prev_rstn = 0;
    logic [7:0] prev_col = '0;
    logic [7:0] sc[$];
    vec_t vecs[4];
    ws2812_chain_sequencer #(.NUM_LEDS(N), .COLOUR_W(8), .LATCH_CYCLES(L)) dut (
        .i_Clock(i_Clock), .i_Rstn(i_Rstn), .i_WrEn(i_WrEn), .i_WrAddr(i_WrAddr),
        .i_WrData(i_WrData), .i_Refresh(i_Refresh), .o_Busy(o_Busy), .o_FrameDone(o_FrameDone),
        .o_Start(o_Start), .o_Colour(o_Colour), .i_Ready(i_Ready)
    );
    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc++;
    // driver model and monitor: ready drops for 10 cycles after each start
    always @(negedge i_Clock) begin
        if (i_Rstn && prev_rstn && !i_Ready) begin
            total++;
            if (o_Colour !== prev_col) begin
                bad++;
                $display("FAIL colour_stable: got %h want %h", o_Colour, prev_col);
            end
        end
        if (o_Start) sc.push_back(o_Colour);
        if (o_FrameDone) begin fd_cnt++; t_fd = cyc; end
        if (o_Busy && !prev_busy) t_load = cyc;
        if (o_Start) drv_cnt = 10; else if (drv_cnt > 0) drv_cnt--;
        if (!i_Ready && drv_cnt == 0 && !force_low) t_rdy = cyc;
        i_Ready = !force_low && drv_cnt == 0;
        prev_col = o_Colour; prev_busy = o_Busy; prev_rstn = i_Rstn;
    end
    task automatic check(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(negedge i_Clock); #1;
    endtask
    task automatic wr(int a, logic [7:0] d);
        i_WrEn = 1; i_WrAddr = AW'(a); i_WrData = d;
        tick();
        i_WrEn = 0;
    endtask
    task automatic refresh_pulse();
        i_Refresh = 1; tick(); i_Refresh = 0;
    endtask
    task automatic wait_fd(int target, string nm);
        int n = 0;
        while (fd_cnt < target && n < 3000) begin tick(); n++; end
        check(nm, int'(fd_cnt >= target), 1);
    endtask
    task automatic wait_starts(int target, string nm);
        int n = 0;
        while (sc.size() < target && n < 3000) begin tick(); n++; end
        check(nm, int'(sc.size() >= target), 1);
    endtask
    initial begin
        int base, f0, fd1, n0, nb;
        vecs[0] = '{5'b11111, 40'h55_44_33_22_11, 8'hAA, 40'h55_44_33_22_11};
        vecs[1] = '{5'b00101, 40'h00_00_03_00_01, 8'hBB, 40'h55_44_03_22_01};
        vecs[2] = '{5'b10000, 40'hFF_00_00_00_00, 8'hCC, 40'hFF_44_03_22_01};
        vecs[3] = '{5'b11111, 40'h3C_C3_00_7F_80, 8'hDD, 40'h3C_C3_00_7F_80};
        repeat (3) tick();
        check("rst_busy", o_Busy, 0);
        check("rst_done", o_FrameDone, 0);
        check("rst_start", o_Start, 0);
        check("rst_colour", o_Colour, 0);
        i_Rstn = 1;
        tick();
`ifdef WS2812_AUTO_REFRESH_EN
        wait_fd(1, "auto_fd1");
        fd1 = t_fd;
        wait_fd(2, "auto_fd2");
        check("auto_period", t_fd - fd1, FRAME_CYC);
        check("auto_reload", t_load, fd1 + 1);
        check("auto_starts", sc.size(), 2 * N);
`else
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N; i++)
                if (vecs[v].mask[i]) wr(i, vecs[v].wr[8*i +: 8]);
            for (int a = N; a < 8; a++) wr(a, vecs[v].junk);
            base = sc.size(); f0 = fd_cnt;
            i_Refresh = 1; tick();
            check("lat_busy", o_Busy, 1);
            check("lat_nostart", o_Start, 0);
            i_Refresh = 0; tick();
            check("lat_start", o_Start, 1);
            wait_fd(f0 + 1, "vec_fd_timeout");
            check("vec_fd_busy", o_Busy, 0);
            check("vec_gap", t_fd - t_rdy, L + 1);
            check("vec_nstart", sc.size() - base, N);
            for (int i = 0; i < N; i++) check($sformatf("vec%0d_led%0d", v, i), sc[base+i], vecs[v].exp[8*i +: 8]);
            tick();
            check("vec_fd_pulse", o_FrameDone, 0);
        end
        base = sc.size(); f0 = fd_cnt;
        i_Refresh = 1; repeat (30) tick(); i_Refresh = 0;
        repeat (10) tick();
        repeat (3) begin refresh_pulse(); repeat (8) tick(); end
        wait_fd(f0 + 1, "pend_fd1");
        fd1 = t_fd;
        wait_fd(f0 + 2, "pend_fd2");
        check("pend_reload", t_load, fd1 + 1);
        repeat (200) tick();
        check("pend_frames", fd_cnt - f0, 2);
        check("pend_starts", sc.size() - base, 2 * N);
        base = sc.size(); f0 = fd_cnt;
        refresh_pulse();
        wait_starts(base + 2, "mid_wait");
        wr(3, 8'h55);
        wr(0, 8'h66);
        wait_fd(f0 + 1, "mid_fd");
        check("mid_led0_old", sc[base], 8'h80);
        check("mid_led3_new", sc[base+3], 8'h55);
        base = sc.size(); f0 = fd_cnt;
        refresh_pulse();
        wait_fd(f0 + 1, "mid_fd2");
        check("next_led0", sc[base], 8'h66);
        check("next_led3", sc[base+3], 8'h55);
        force_low = 1; tick();
        base = sc.size(); f0 = fd_cnt; nb = 0;
        refresh_pulse();
        repeat (50) begin tick(); if (!o_Busy) nb++; end
        check("rdylow_busy", nb, 0);
        check("rdylow_nostart", sc.size() - base, 0);
        force_low = 0;
        wait_fd(f0 + 1, "rdylow_fd");
        check("rdylow_starts", sc.size() - base, N);
        wr(2, 8'h99);
        base = sc.size();
        refresh_pulse();
        wait_starts(base + 3, "rst_wait");
        repeat (4) tick();
        check("pre_rst_busy", o_Busy, 1);
        check("pre_rst_colour", o_Colour, 8'h99);
        i_Rstn = 0; #1;
        check("mid_rst_busy", o_Busy, 0);
        check("mid_rst_start", o_Start, 0);
        check("mid_rst_colour", o_Colour, 0);
        check("mid_rst_done", o_FrameDone, 0);
        repeat (3) tick();
        i_Rstn = 1;
        n0 = sc.size();
        repeat (40) tick();
        check("post_rst_nostart", sc.size() - n0, 0);
        check("post_rst_busy", o_Busy, 0);
        base = sc.size(); f0 = fd_cnt;
        refresh_pulse();
        wait_fd(f0 + 1, "clr_fd");
        check("clr_starts", sc.size() - base, N);
        for (int i = 0; i < N; i++) check($sformatf("clr_led%0d", i), sc[base+i], 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
